delay_channel: RTL
==================

// Module: delay_channel
// PURPOSE
//  Multi-lane, run-time programmable delay line. Models the link latency between
//  distributed nodes. Generalises the fixed-delay channel:
//  - NCH lanes share one valid bit.
//  - Delay is reloadable at run time without reset.
//  - Invalid slots read as zero.
//  Sits between a node's output port and the peer node's input port.
// PARAMETERS
//  DWIDTH     32       data bits per lane
//  NCH        4        number of lanes carried together
//  MAX_DELAY  64       largest supported delay in cycles (>=2)
//  INIT_DELAY 64       delay in force after reset (1..MAX_DELAY)
//  LFSR_SEED  16'hACE1 loss-LFSR reset value; must be non-zero (CHANNEL_LOSS_EN only)
// PORTS
//  clk         in   1               clock; all state on rising edge
//  rst_n       in   1               asynchronous active-low reset
//  cfg_load    in   1               1-cycle strobe: load delay_cfg
//  delay_cfg   in   $clog2(MAX_DELAY+1)  requested delay in cycles
//  cur_delay   out  $clog2(MAX_DELAY+1)  delay currently in force
//  in_valid    in   1               in_data holds a word this cycle
//  in_data     in   NCH*DWIDTH      lane k = bits [k*DWIDTH +: DWIDTH]
//  out_valid   out  1               out_data holds a delayed word
//  out_data    out  NCH*DWIDTH      delayed data; all-zero when out_valid=0
//  loss_thresh in   8               drop threshold (used only with CHANNEL_LOSS_EN)
//  drop_cnt    out  16              words dropped, saturating
// BEHAVIOUR
//  Reset:
//  - Async assert clears all stored valid and data bits.
//  - cur_delay=INIT_DELAY; out_valid=0, out_data=0, drop_cnt=0; LFSR=LFSR_SEED.
//  Storage:
//  - MAX_DELAY-entry shift register of {valid, data}.
//  - Entry 0 loads {in_valid, in_valid ? in_data : 0} every cycle. No backpressure.
//  - Output taps entry cur_delay-1, registered.
//  - A word sampled on edge N appears on out_* after edge N+cur_delay-1, i.e. it is
//    visible for exactly one cycle, cur_delay cycles after it was presented.
//  - Back-to-back valid words emerge back-to-back. Idle gaps are preserved exactly.
//  Delay load:
//  - cfg_load=1 at edge N: cur_delay <= clamp(delay_cfg).
//  - clamp: 0 -> 1; values >MAX_DELAY -> MAX_DELAY.
//  - Same edge: every stored valid bit is cleared. In-flight words are discarded, never
//    duplicated or reordered.
//  - The word presented on the cfg_load cycle is kept and emerges with the new delay.
//  - out_valid=0 from the cycle after the load edge until the first post-load word
//    arrives.
//  - cfg_load with an unchanged delay still flushes.
//  Width/arith:
//  - Lanes are opaque; no per-lane logic.
//  - drop_cnt saturates at 16'hFFFF and never wraps.
//  Reset mid-operation: all in-flight words are lost; no partial word is emitted after
//  release.
// CONFIGURATION
//  CHANNEL_LOSS_EN defined:
//  - 16-bit Fibonacci LFSR, taps 16,14,13,11, shifts every cycle from LFSR_SEED.
//  - A valid input is dropped (stored as invalid) when lfsr[7:0] < loss_thresh.
//  - Each drop increments drop_cnt.
//  - loss_thresh=0 never drops. 255 drops all words except those with lfsr[7:0]=255.
//  CHANNEL_LOSS_EN undefined:
//  - No LFSR; loss_thresh is ignored; drop_cnt ties to 0; all valid words delivered.
//  - Ports stay present in both builds.
// TESTING
//  1 Reset, INIT_DELAY=64; in_valid=1 data 32'h1/lane for one cycle -> out_valid
//    high exactly 64 cycles later, 1 cycle wide, data matches; out_data=0 otherwise.
//  2 cfg_load delay_cfg=3, then stream 10 consecutive words 0..9 -> each emerges
//    3 cycles after input, consecutive, in order; cur_delay reads 3.
//  3 Stream at delay 8; cfg_load delay_cfg=2 mid-stream -> no pre-load words emerge;
//    load-cycle word out 2 cycles later; no duplicates.
//  4 delay_cfg=0 -> cur_delay=1; delay_cfg=MAX_DELAY+5 -> cur_delay=MAX_DELAY.
//  5 rst_n low for 1 cycle with 5 words in flight -> all outputs 0 immediately (async);
//    nothing emerges afterwards.
//  6 LOSS_EN, loss_thresh=0 for 1000 words -> drop_cnt=0.
//    loss_thresh=128 -> drop_cnt equals the reference LFSR-model count.
//    Delivered + dropped = 1000.

Source files
------------

// File: rtl/delay_channel.sv
// Multi-lane programmable delay line modelling node-to-node link latency; optional loss model under `CHANNEL_LOSS_EN.
// Latency: a word presented in cycle c is visible on out_* in cycle c+cur_delay, for exactly one cycle.
// Backpressure: none; a word is accepted every cycle, and cfg_load flushes all in-flight words.
module delay_channel #(
    parameter int          DWIDTH     = 32,
    parameter int          NCH        = 4,
    parameter int          MAX_DELAY  = 64,
    parameter int          INIT_DELAY = 64,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    localparam int         NW         = DWIDTH * NCH,
    localparam int         CW         = $clog2(MAX_DELAY + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_load,
    input  logic [CW-1:0] delay_cfg,
    output logic [CW-1:0] cur_delay,
    input  logic          in_valid,
    input  logic [NW-1:0] in_data,
    output logic          out_valid,
    output logic [NW-1:0] out_data,
    input  logic [7:0]    loss_thresh,
    output logic [15:0]   drop_cnt
);

    typedef struct packed {
        logic          vld;
        logic [NW-1:0] dat;
    } slot_t;

    // The output register is the last stage, so the line itself needs one fewer slot.
    localparam int NSLOT = MAX_DELAY - 1;

    slot_t         line_q [NSLOT];
    logic          in_keep;
    logic [CW-1:0] load_delay;
    logic          tap_vld;
    logic [NW-1:0] tap_dat;
    logic          nxt_vld;
    logic [NW-1:0] nxt_dat;

    function automatic logic [CW-1:0] clamp_delay(input logic [CW-1:0] d);
        if (d == '0)
            return CW'(1);
        else if (d > CW'(MAX_DELAY))
            return CW'(MAX_DELAY);
        else
            return d;
    endfunction

    assign load_delay = clamp_delay(delay_cfg);

`ifdef CHANNEL_LOSS_EN
    logic [15:0] lfsr_q;
    logic        drop;

    assign drop    = in_valid && (lfsr_q[7:0] < loss_thresh);
    assign in_keep = in_valid && !drop;

    // Fibonacci LFSR, taps 16,14,13,11; free-running from reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    logic unused_loss;

    assign unused_loss = ^{loss_thresh, LFSR_SEED};
    assign in_keep     = in_valid;
    assign drop_cnt    = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_delay <= CW'(INIT_DELAY);
        end else if (cfg_load) begin
            cur_delay <= load_delay;
        end
    end

    // A load clears only the valid bits; stale data is masked at the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSLOT; k++) begin
                line_q[k] <= '0;
            end
        end else begin
            line_q[0].vld <= in_keep;
            line_q[0].dat <= in_keep ? in_data : '0;
            for (int k = 1; k < NSLOT; k++) begin
                line_q[k].vld <= line_q[k-1].vld & ~cfg_load;
                line_q[k].dat <= line_q[k-1].dat;
            end
        end
    end

    always_comb begin
        tap_vld = 1'b0;
        tap_dat = '0;
        for (int k = 0; k < NSLOT; k++) begin
            if (cur_delay == CW'(k + 2)) begin
                tap_vld = line_q[k].vld;
                tap_dat = line_q[k].dat;
            end
        end
    end

    // On a load edge nothing old may leave; only a delay-1 load passes the current word straight through.
    always_comb begin
        nxt_vld = 1'b0;
        nxt_dat = '0;
        if (cfg_load) begin
            if (load_delay == CW'(1)) begin
                nxt_vld = in_keep;
                nxt_dat = in_data;
            end
        end else if (cur_delay == CW'(1)) begin
            nxt_vld = in_keep;
            nxt_dat = in_data;
        end else begin
            nxt_vld = tap_vld;
            nxt_dat = tap_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= nxt_vld;
            out_data  <= nxt_vld ? nxt_dat : '0;
        end
    end

endmodule
